serial_link_port: RTL and testbench



---
 rtl/serial_link_port.sv | 164 ++++++++++++++++
 tb/tb_serial_link_port.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_port.sv
// Serial link port: SB/SC IO registers plus an 8-bit full-duplex shifter
// clocked either internally (divided I_CLK) or by the link partner.
module serial_link_port #(
    parameter logic [15:0] SB_ADDR     = 16'hFF01,
    parameter logic [15:0] SC_ADDR     = 16'hFF02,
    parameter int          HALF_PERIOD = 256,
    parameter int          CNT_W       = 9
) (
    input  logic        I_CLK,
    input  logic        I_SYNC_RESET,
    input  logic [15:0] I_IOREG_ADDR,
    inout  wire  [7:0]  IO_IOREG_DATA,
    input  logic        I_IOREG_WE_L,
    input  logic        I_IOREG_RE_L,
    input  logic        I_SCLK,
    input  logic        I_SIN,
    output logic        O_SCLK,
    output logic        O_SOUT,
    output logic        O_SERIAL_INT
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        EXT
    } state_t;

    state_t           state;
    logic [7:0]       sb;
    logic             sc_start;
    logic             sc_clk_sel;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] half_cnt;
    logic [2:0]       sclk_sync;
    logic [1:0]       sin_sync;

    logic [7:0] wr_data;
    logic       sb_wr;
    logic       sc_wr;
    logic       sb_rd;
    logic       sc_rd;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       sin_bit;
    logic       done_int;
    logic       done_ext;

    assign wr_data = IO_IOREG_DATA;
    assign sb_wr   = !I_IOREG_WE_L && (I_IOREG_ADDR == SB_ADDR);
    assign sc_wr   = !I_IOREG_WE_L && (I_IOREG_ADDR == SC_ADDR);
    assign sb_rd   = !I_IOREG_RE_L && (I_IOREG_ADDR == SB_ADDR);
    assign sc_rd   = !I_IOREG_RE_L && (I_IOREG_ADDR == SC_ADDR);

    assign IO_IOREG_DATA = sb_rd ? sb :
                           sc_rd ? {sc_start, 6'b111111, sc_clk_sel} :
                           8'bz;

    // Edges come from stage 2 against a third registered copy of I_SCLK.
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign sin_bit   = sin_sync[1];

    assign done_int = (state == HIGH) && (half_cnt == HALF_LAST) && (bit_cnt == 4'd8);
    assign done_ext = (state == EXT) && (bit_cnt == 4'd8);

    // Completion takes priority over a same-cycle SC write, which is dropped.
    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RESET) begin
            state        <= IDLE;
            sb           <= 8'h00;
            sc_start     <= 1'b0;
            sc_clk_sel   <= 1'b0;
            bit_cnt      <= 4'd0;
            half_cnt     <= '0;
            sclk_sync    <= 3'b111;
            sin_sync     <= 2'b11;
            O_SCLK       <= 1'b1;
            O_SOUT       <= 1'b1;
            O_SERIAL_INT <= 1'b0;
        end else begin
            sclk_sync    <= {sclk_sync[1:0], I_SCLK};
            sin_sync     <= {sin_sync[0], I_SIN};
            O_SERIAL_INT <= 1'b0;

            if (state == IDLE) begin
                if (sb_wr) begin
                    sb <= wr_data;
                end
                if (sc_wr) begin
                    sc_clk_sel <= wr_data[0];
                    sc_start   <= wr_data[7];
                    if (wr_data[7]) begin
                        bit_cnt  <= 4'd0;
                        half_cnt <= '0;
                        if (wr_data[0]) begin
                            state  <= LOW;
                            O_SCLK <= 1'b0;
                            O_SOUT <= sb[7];
                        end else begin
                            state  <= EXT;
                            O_SCLK <= 1'b1;
                        end
                    end
                end
            end else if (done_int || done_ext) begin
                state        <= IDLE;
                sc_start     <= 1'b0;
                half_cnt     <= '0;
                O_SCLK       <= 1'b1;
                O_SOUT       <= 1'b1;
                O_SERIAL_INT <= 1'b1;
            end else if (sc_wr && !wr_data[7]) begin
                // Abort leaves SB holding whatever has been shifted so far.
                state    <= IDLE;
                sc_start <= 1'b0;
                bit_cnt  <= 4'd0;
                half_cnt <= '0;
                O_SCLK   <= 1'b1;
                O_SOUT   <= 1'b1;
            end else begin
                case (state)
                    LOW: begin
                        if (half_cnt == HALF_LAST) begin
                            state    <= HIGH;
                            half_cnt <= '0;
                            O_SCLK   <= 1'b1;
                            sb       <= {sb[6:0], sin_bit};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end else begin
                            half_cnt <= half_cnt + CNT_W'(1);
                        end
                    end
                    HIGH: begin
                        if (half_cnt == HALF_LAST) begin
                            state    <= LOW;
                            half_cnt <= '0;
                            O_SCLK   <= 1'b0;
                            O_SOUT   <= sb[7];
                        end else begin
                            half_cnt <= half_cnt + CNT_W'(1);
                        end
                    end
                    EXT: begin
                        O_SCLK <= 1'b1;
                        if (sclk_fall) begin
                            O_SOUT <= sb[7];
                        end
                        if (sclk_rise) begin
                            sb      <= {sb[6:0], sin_bit};
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_link_port.sv
// Directed bench for serial_link_port: register vectors from a table, then
// hand-written internal, external, abort, protection and reset sequences.
module tb_serial_link_port;

    localparam int          HP      = 4;
    localparam logic [15:0] SB_ADDR = 16'hFF01;
    localparam logic [15:0] SC_ADDR = 16'hFF02;

    logic        I_CLK = 1'b0;
    logic        I_SYNC_RESET;
    logic [15:0] addr;
    logic        we_l;
    logic        re_l;
    logic        I_SCLK;
    logic        I_SIN;
    wire         O_SCLK;
    wire         O_SOUT;
    wire         O_SERIAL_INT;
    wire  [7:0]  io_data;
    logic        tb_oe;
    logic [7:0]  tb_wdata;

    // Pull-ups make an undriven bus read back as 8'hFF.
    assign io_data = tb_oe ? tb_wdata : 8'bz;
    for (genvar g = 0; g < 8; g++) begin : g_pull
        pullup (io_data[g]);
    end

    always #5 I_CLK = ~I_CLK;

    serial_link_port #(
        .SB_ADDR(SB_ADDR),
        .SC_ADDR(SC_ADDR),
        .HALF_PERIOD(HP),
        .CNT_W(9)
    ) dut (
        .I_CLK(I_CLK),
        .I_SYNC_RESET(I_SYNC_RESET),
        .I_IOREG_ADDR(addr),
        .IO_IOREG_DATA(io_data),
        .I_IOREG_WE_L(we_l),
        .I_IOREG_RE_L(re_l),
        .I_SCLK(I_SCLK),
        .I_SIN(I_SIN),
        .O_SCLK(O_SCLK),
        .O_SOUT(O_SOUT),
        .O_SERIAL_INT(O_SERIAL_INT)
    );

    typedef struct packed {
        logic        do_wr;
        logic [15:0] waddr;
        logic [7:0]  wdata;
        logic        do_rd;
        logic [15:0] raddr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t       vecs[11];
    int         checks = 0;
    int         errors = 0;
    int         int_seen;
    logic [7:0] rd_val;
    logic [7:0] pat_out;
    logic [7:0] pat_in;
    logic [7:0] collected;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; the write lands on the following rising edge.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        addr     = a;
        tb_wdata = d;
        tb_oe    = 1'b1;
        we_l     = 1'b0;
        @(negedge I_CLK);
        we_l  = 1'b1;
        tb_oe = 1'b0;
        addr  = 16'h0000;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
        addr = a;
        re_l = 1'b0;
        #1;
        d    = io_data;
        re_l = 1'b1;
        addr = 16'h0000;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge I_CLK);
            if (O_SERIAL_INT) int_seen++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.do_wr) cpu_write(v.waddr, v.wdata);
        addr = v.raddr;
        re_l = ~v.do_rd;
        #1;
        rd_val = io_data;
        re_l   = 1'b1;
        addr   = 16'h0000;
    endtask

    initial begin
        I_SYNC_RESET = 1'b1;
        addr     = 16'h0000;
        we_l     = 1'b1;
        re_l     = 1'b1;
        tb_oe    = 1'b0;
        tb_wdata = 8'h00;
        I_SCLK   = 1'b1;
        I_SIN    = 1'b1;
        int_seen = 0;

        repeat (2) @(negedge I_CLK);
        I_SYNC_RESET = 1'b0;
        checkOutput("rst_sclk", {7'd0, O_SCLK}, 8'd1);
        checkOutput("rst_sout", {7'd0, O_SOUT}, 8'd1);
        checkOutput("rst_int", {7'd0, O_SERIAL_INT}, 8'd0);

        vecs[0]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hFF01, 8'h00};
        vecs[1]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hFF02, 8'h7E};
        vecs[2]  = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hFF03, 8'hFF};
        vecs[3]  = '{1'b0, 16'h0000, 8'h00, 1'b0, 16'hFF01, 8'hFF};
        vecs[4]  = '{1'b1, 16'hFF01, 8'hA5, 1'b1, 16'hFF01, 8'hA5};
        vecs[5]  = '{1'b1, 16'hFF02, 8'h01, 1'b1, 16'hFF02, 8'h7F};
        vecs[6]  = '{1'b1, 16'hFF02, 8'h00, 1'b1, 16'hFF02, 8'h7E};
        vecs[7]  = '{1'b1, 16'hFF03, 8'h12, 1'b1, 16'hFF01, 8'hA5};
        vecs[8]  = '{1'b1, 16'hFF02, 8'h41, 1'b1, 16'hFF02, 8'h7F};
        vecs[9]  = '{1'b1, 16'hFF01, 8'h3C, 1'b1, 16'hFF01, 8'h3C};
        vecs[10] = '{1'b0, 16'h0000, 8'h00, 1'b1, 16'hFF00, 8'hFF};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), rd_val, vecs[i].exp_data);
        end
        checkOutput("idle_sout", {7'd0, O_SOUT}, 8'd1);

        // Internal transfer: SB=A5 out, 3C in, 4-cycle half periods.
        @(negedge I_CLK);
        pat_out = 8'hA5;
        pat_in  = 8'h3C;
        I_SIN   = 1'b0;
        int_seen = 0;
        cpu_write(SB_ADDR, pat_out);
        cpu_write(SC_ADDR, 8'h81);
        for (int k = 1; k <= 70; k++) begin
            if (k > 1) @(negedge I_CLK);
            if (O_SERIAL_INT) begin
                int_seen++;
                checkOutput("int_pulse_cycle", 8'(k), 8'd65);
            end
            if (k <= 64) begin
                if ((k - 1) % 8 == 0) I_SIN = pat_in[7 - (k - 1) / 8];
                checkOutput("int_sclk", {7'd0, O_SCLK}, ((k - 1) % 8 < 4) ? 8'd0 : 8'd1);
                if ((k - 1) % 8 == 3)
                    checkOutput("int_sout", {7'd0, O_SOUT}, {7'd0, pat_out[7 - (k - 1) / 8]});
            end
        end
        checkOutput("int_pulses", 8'(int_seen), 8'd1);
        checkOutput("int_end_sout", {7'd0, O_SOUT}, 8'd1);
        cpu_read(SB_ADDR, rd_val);
        checkOutput("int_sb", rd_val, 8'h3C);
        cpu_read(SC_ADDR, rd_val);
        checkOutput("int_sc", rd_val, 8'h7F);

        // External transfer: partner clock with 20-cycle halves, SIN=1.
        @(negedge I_CLK);
        pat_out = 8'h0F;
        I_SIN   = 1'b1;
        cpu_write(SB_ADDR, pat_out);
        cpu_write(SC_ADDR, 8'h80);
        int_seen = 0;
        for (int b = 0; b < 8; b++) begin
            I_SCLK = 1'b0;
            step(20);
            checkOutput("ext_sout", {7'd0, O_SOUT}, {7'd0, pat_out[7 - b]});
            checkOutput("ext_sclk", {7'd0, O_SCLK}, 8'd1);
            I_SCLK = 1'b1;
            step(20);
        end
        checkOutput("ext_pulses", 8'(int_seen), 8'd1);
        cpu_read(SB_ADDR, rd_val);
        checkOutput("ext_sb", rd_val, 8'hFF);
        cpu_read(SC_ADDR, rd_val);
        checkOutput("ext_sc", rd_val, 8'h7E);

        // Abort after three bits, then a clean full transfer.
        @(negedge I_CLK);
        cpu_write(SB_ADDR, 8'hA5);
        int_seen = 0;
        cpu_write(SC_ADDR, 8'h81);
        step(23);
        cpu_write(SC_ADDR, 8'h01);
        checkOutput("abort_sclk", {7'd0, O_SCLK}, 8'd1);
        checkOutput("abort_sout", {7'd0, O_SOUT}, 8'd1);
        checkOutput("abort_int", {7'd0, O_SERIAL_INT}, 8'd0);
        cpu_read(SC_ADDR, rd_val);
        checkOutput("abort_sc", rd_val, 8'h7F);
        cpu_read(SB_ADDR, rd_val);
        checkOutput("abort_sb", rd_val, 8'h2F);
        step(80);
        checkOutput("abort_no_int", 8'(int_seen), 8'd0);
        I_SIN = 1'b0;
        cpu_write(SB_ADDR, 8'hC3);
        cpu_write(SC_ADDR, 8'h81);
        step(70);
        checkOutput("restart_pulses", 8'(int_seen), 8'd1);
        cpu_read(SB_ADDR, rd_val);
        checkOutput("restart_sb", rd_val, 8'h00);

        // Writes during a transfer must not disturb the outgoing data.
        @(negedge I_CLK);
        cpu_write(SB_ADDR, 8'hA5);
        int_seen = 0;
        cpu_write(SC_ADDR, 8'h81);
        cpu_write(SB_ADDR, 8'h55);
        cpu_write(SC_ADDR, 8'h81);
        collected = 8'h00;
        for (int k = 4; k <= 70; k++) begin
            if (k > 4) @(negedge I_CLK);
            if (O_SERIAL_INT) int_seen++;
            if (k <= 64 && (k - 1) % 8 == 3) collected = {collected[6:0], O_SOUT};
        end
        checkOutput("prot_data", collected, 8'hA5);
        checkOutput("prot_pulses", 8'(int_seen), 8'd1);

        // SC write landing on the completion edge is dropped.
        @(negedge I_CLK);
        I_SIN = 1'b1;
        cpu_write(SB_ADDR, 8'hA5);
        int_seen = 0;
        cpu_write(SC_ADDR, 8'h81);
        step(63);
        cpu_write(SC_ADDR, 8'h80);
        checkOutput("coll_int", {7'd0, O_SERIAL_INT}, 8'd1);
        step(2);
        checkOutput("coll_single", 8'(int_seen), 8'd0);
        cpu_read(SC_ADDR, rd_val);
        checkOutput("coll_sc", rd_val, 8'h7F);
        cpu_read(SB_ADDR, rd_val);
        checkOutput("coll_sb", rd_val, 8'hFF);

        // Reset in the middle of bit 5.
        @(negedge I_CLK);
        cpu_write(SB_ADDR, 8'hA5);
        int_seen = 0;
        cpu_write(SC_ADDR, 8'h81);
        step(41);
        checkOutput("mid_sclk_low", {7'd0, O_SCLK}, 8'd0);
        I_SYNC_RESET = 1'b1;
        @(negedge I_CLK);
        checkOutput("rst2_sclk", {7'd0, O_SCLK}, 8'd1);
        checkOutput("rst2_sout", {7'd0, O_SOUT}, 8'd1);
        checkOutput("rst2_int", {7'd0, O_SERIAL_INT}, 8'd0);
        @(negedge I_CLK);
        I_SYNC_RESET = 1'b0;
        cpu_read(SB_ADDR, rd_val);
        checkOutput("rst2_sb", rd_val, 8'h00);
        cpu_read(SC_ADDR, rd_val);
        checkOutput("rst2_sc", rd_val, 8'h7E);
        step(80);
        checkOutput("rst2_no_int", 8'(int_seen), 8'd0);
        checkOutput("rst2_idle_sclk", {7'd0, O_SCLK}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
